bus_arbiter: RTL and testbench
==============================

BUS_ARBITER -- requirements
Module: bus_arbiter

Interface
REQ-001 SHALL have parameter BEGIN_TIMEOUT, default 16: maximum cycles between grant and beginTransactionIn.
REQ-002 SHALL have parameter IDLE_TIMEOUT, default 1024: maximum cycles without bus activity inside a transaction.
REQ-003 SHALL have port clock, input, 1: single system clock; all logic on rising edge.
REQ-004 SHALL have port reset, input, 1: synchronous, active-low reset.
REQ-005 SHALL have port requests, input, 4: per-master bus request, level-sensitive.
REQ-006 SHALL have port grants, output, 4: per-master grant, registered, one-hot or zero.
REQ-007 SHALL have port beginTransactionIn, input, 1: shared-bus transaction start.
REQ-008 SHALL have port endTransactionIn, input, 1: shared-bus transaction end.
REQ-009 SHALL have port dataValidIn, input, 1: shared-bus data beat.
REQ-010 SHALL have port busyIn, input, 1: slave busy.
REQ-011 SHALL have port busErrorIn, input, 1: slave bus error.
REQ-012 SHALL have port endTransactionOut, output, 1: arbiter-forced end of transaction, one-cycle pulse.
REQ-013 SHALL have port busErrorOut, output, 1: arbiter-detected timeout error, one-cycle pulse.
REQ-014 SHALL have port activeMaster, output, 2: index of the current or last granted master.
REQ-015 SHALL have port busIdle, output, 1: high when state is IDLE.

Function
REQ-016 SHALL implement states IDLE, GRANT, ACTIVE and RELEASE.
REQ-017 IDLE: if any requests bit is set, SHALL select a winner round-robin, starting at (last winner + 1) mod 4, and go to GRANT.
REQ-018 The grants bit of the winner SHALL be high from the cycle after the request is sampled until the cycle the arbiter leaves ACTIVE; request-to-grant latency is 1 cycle.
REQ-019 GRANT: beginTransactionIn SHALL move the arbiter to ACTIVE.
REQ-020 GRANT: if the winner drops its request, the arbiter SHALL go to RELEASE without pulsing endTransactionOut.
REQ-021 GRANT: when BEGIN_TIMEOUT cycles elapse without beginTransactionIn, the arbiter SHALL go to RELEASE and pulse busErrorOut.
REQ-022 ACTIVE: endTransactionIn or busErrorIn SHALL move the arbiter to RELEASE on the next cycle.
REQ-023 ACTIVE: the watchdog counter SHALL reload to IDLE_TIMEOUT-1 on any cycle with dataValidIn or busyIn high, and otherwise decrement.
REQ-024 ACTIVE: when the watchdog reaches 0, the arbiter SHALL pulse endTransactionOut and busErrorOut for one cycle each and go to RELEASE.
REQ-025 RELEASE SHALL last exactly 1 cycle (bus turnaround) with grants = 0, then go to IDLE.
REQ-026 No grant SHALL be issued in the RELEASE cycle.
REQ-027 The counter width SHALL be clog2 of the larger timeout.
REQ-028 The last-winner pointer SHALL update only on entry to GRANT.
REQ-029 A single requester SHALL be re-granted after RELEASE; back-to-back grant spacing is at least 2 cycles (RELEASE, then IDLE).
REQ-030 If busErrorIn and endTransactionIn are high together, the result SHALL be a single transition to RELEASE and busErrorOut SHALL stay low (the error is slave-reported).
REQ-031 A watchdog expiry coinciding with endTransactionIn SHALL be ignored: endTransactionIn wins and there are no pulses.
REQ-032 In IDLE, beginTransactionIn, endTransactionIn and all other bus inputs SHALL be ignored.
REQ-033 Requests from non-winners SHALL never affect the current grant; no preemption.

Reset
REQ-034 With reset low at a rising edge, the arbiter SHALL be in IDLE with grants=0, endTransactionOut=0, busErrorOut=0, activeMaster=3 (so master 0 wins first), busIdle=1, and counters cleared.
REQ-035 Reset asserted in any state, mid-transaction included, SHALL take effect on that edge, with grants dropping the following cycle.

Verification
REQ-036 requests=4'b0101 held, each master ends after one beat: grants sequence 0001, 0100, 0001, 0100; each grant 1 cycle after IDLE.
REQ-037 requests=4'b1000, no beginTransactionIn for 16 cycles: busErrorOut pulses once, RELEASE, then grants=1000 again.
REQ-038 Grant master 2, begin, then no dataValidIn/busyIn for 1024 cycles: endTransactionOut and busErrorOut pulse together, grants=0 the next cycle.
REQ-039 busErrorIn and endTransactionIn asserted in the same ACTIVE cycle: one RELEASE, busErrorOut=0.
REQ-040 Reset low during ACTIVE with grants=0010: grants=0000, busIdle=1 the next cycle, and the first subsequent grant goes to the lowest requesting index from 0.
REQ-041 Winner drops its request in GRANT: RELEASE, no pulses, and the next requester is granted 2 cycles later.

Source files
------------

// File: rtl/bus_arbiter.sv
// bus_arbiter: four-master round-robin arbiter for a shared bus, with timeouts.
//
// Ports
//   clock              rising-edge system clock
//   reset              synchronous, active-low reset
//   requests[3:0]      per-master level-sensitive bus request
//   grants[3:0]        per-master grant, registered, one-hot or zero
//   beginTransactionIn shared-bus transaction start
//   endTransactionIn   shared-bus transaction end
//   dataValidIn        shared-bus data beat (keeps the idle watchdog alive)
//   busyIn             slave busy (keeps the idle watchdog alive)
//   busErrorIn         slave-reported bus error (ends the transaction)
//   endTransactionOut  arbiter-forced end of transaction, one-cycle pulse
//   busErrorOut        arbiter-detected timeout error, one-cycle pulse
//   activeMaster[1:0]  index of the current or last granted master
//   busIdle            high while the arbiter is in IDLE
//
// Flow: IDLE -> GRANT -> ACTIVE -> RELEASE -> IDLE. GRANT waits at most
// BEGIN_TIMEOUT cycles for beginTransactionIn; ACTIVE aborts after
// IDLE_TIMEOUT consecutive cycles with neither dataValidIn nor busyIn.
// RELEASE is a single turnaround cycle with no grant.
//
// The timeout pulses are decoded from the registered state and counter in
// the last GRANT/ACTIVE cycle, so they appear while the grant is still up
// and the grant drops on the following cycle.

module bus_arbiter #(
    parameter int BEGIN_TIMEOUT = 16,
    parameter int IDLE_TIMEOUT  = 1024
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [3:0] requests,
    output logic [3:0] grants,
    input  logic       beginTransactionIn,
    input  logic       endTransactionIn,
    input  logic       dataValidIn,
    input  logic       busyIn,
    input  logic       busErrorIn,
    output logic       endTransactionOut,
    output logic       busErrorOut,
    output logic [1:0] activeMaster,
    output logic       busIdle
);

    localparam int MAX_TIMEOUT = (BEGIN_TIMEOUT > IDLE_TIMEOUT) ? BEGIN_TIMEOUT : IDLE_TIMEOUT;
    localparam int CNT_W       = (MAX_TIMEOUT > 2) ? $clog2(MAX_TIMEOUT) : 1;

    localparam logic [CNT_W-1:0] BEGIN_LOAD = CNT_W'(BEGIN_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] IDLE_LOAD  = CNT_W'(IDLE_TIMEOUT - 1);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_GRANT   = 2'd1,
        ST_ACTIVE  = 2'd2,
        ST_RELEASE = 2'd3
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [1:0]       last_q, last_d;
    logic [3:0]       grants_q, grants_d;

    logic             rr_found;
    logic [1:0]       rr_idx;
    logic             end_pulse;
    logic             err_pulse;

    // Round-robin pick: scan last+1, last+2, last+3 and finally last itself,
    // so the previous winner is only chosen when nobody else is asking.
    always_comb begin
        rr_found = 1'b0;
        rr_idx   = last_q;
        for (int off = 1; off <= 4; off++) begin
            if (!rr_found && requests[last_q + 2'(off)]) begin
                rr_found = 1'b1;
                rr_idx   = last_q + 2'(off);
            end
        end
    end

    // Next-state, counter and pulse logic.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        last_d    = last_q;
        end_pulse = 1'b0;
        err_pulse = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                // Bus inputs are deliberately ignored here.
                if (rr_found) begin
                    state_d = ST_GRANT;
                    last_d  = rr_idx;
                    cnt_d   = BEGIN_LOAD;
                end
            end

            ST_GRANT: begin
                if (beginTransactionIn) begin
                    state_d = ST_ACTIVE;
                    cnt_d   = IDLE_LOAD;
                end else if (!requests[last_q]) begin
                    // Winner withdrew before starting: quiet release.
                    state_d = ST_RELEASE;
                end else if (cnt_q == '0) begin
                    state_d   = ST_RELEASE;
                    err_pulse = 1'b1;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end

            ST_ACTIVE: begin
                // A normal or slave-reported end beats a simultaneous
                // watchdog expiry, and never raises our own error.
                if (endTransactionIn || busErrorIn) begin
                    state_d = ST_RELEASE;
                end else if (dataValidIn || busyIn) begin
                    cnt_d = IDLE_LOAD;
                end else if (cnt_q == '0) begin
                    state_d   = ST_RELEASE;
                    end_pulse = 1'b1;
                    err_pulse = 1'b1;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end

            ST_RELEASE: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end

            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // Grant register follows the next state so the grant appears the cycle
    // after the request is sampled and drops as the arbiter leaves ACTIVE.
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_grant
            assign grants_d[gi] = ((state_d == ST_GRANT) || (state_d == ST_ACTIVE)) &&
                                  (last_d == 2'(gi));
        end
    endgenerate

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            last_q   <= 2'd3;
            grants_q <= 4'b0000;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            last_q   <= last_d;
            grants_q <= grants_d;
        end
    end

    assign grants            = grants_q;
    assign endTransactionOut = end_pulse;
    assign busErrorOut       = err_pulse;
    assign activeMaster      = last_q;
    assign busIdle           = (state_q == ST_IDLE);

endmodule

// File: tb/tb_bus_arbiter.sv
// Directed testbench for bus_arbiter: reset state, round-robin ordering,
// begin timeout, idle watchdog, simultaneous end/error, mid-transaction reset,
// winner withdrawal and bus inputs in IDLE.

module tb_bus_arbiter;

    logic       clock;
    logic       reset;
    logic [3:0] requests;
    logic [3:0] grants;
    logic       beginTransactionIn;
    logic       endTransactionIn;
    logic       dataValidIn;
    logic       busyIn;
    logic       busErrorIn;
    logic       endTransactionOut;
    logic       busErrorOut;
    logic [1:0] activeMaster;
    logic       busIdle;

    int checks = 0;
    int errors = 0;

    bus_arbiter #(
        .BEGIN_TIMEOUT(16),
        .IDLE_TIMEOUT (1024)
    ) dut (
        .clock             (clock),
        .reset             (reset),
        .requests          (requests),
        .grants            (grants),
        .beginTransactionIn(beginTransactionIn),
        .endTransactionIn  (endTransactionIn),
        .dataValidIn       (dataValidIn),
        .busyIn            (busyIn),
        .busErrorIn        (busErrorIn),
        .endTransactionOut (endTransactionOut),
        .busErrorOut       (busErrorOut),
        .activeMaster      (activeMaster),
        .busIdle           (busIdle)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One complete transaction starting from IDLE with requests already held:
    // GRANT, begin, one beat ending the transfer, RELEASE, back to IDLE.
    task automatic one_beat_txn(input string tag, input logic [3:0] exp_grant);
        tick();
        chk({tag, "_grant"}, grants, exp_grant);
        beginTransactionIn = 1'b1;
        tick();
        chk({tag, "_active_grant"}, grants, exp_grant);
        beginTransactionIn = 1'b0;
        dataValidIn        = 1'b1;
        endTransactionIn   = 1'b1;
        #1;
        chk({tag, "_no_pulses"}, {endTransactionOut, busErrorOut}, 2'b00);
        tick();
        dataValidIn      = 1'b0;
        endTransactionIn = 1'b0;
        chk({tag, "_release"}, {grants, busIdle}, {4'b0000, 1'b0});
        tick();
        chk({tag, "_idle"}, {grants, busIdle}, {4'b0000, 1'b1});
    endtask

    initial begin
        int early_pulses;

        reset              = 1'b0;
        requests           = 4'b0000;
        beginTransactionIn = 1'b0;
        endTransactionIn   = 1'b0;
        dataValidIn        = 1'b0;
        busyIn             = 1'b0;
        busErrorIn         = 1'b0;

        // Reset state.
        tick();
        tick();
        chk("rst_grants", grants, 4'b0000);
        chk("rst_busIdle", busIdle, 1'b1);
        chk("rst_activeMaster", activeMaster, 2'd3);
        chk("rst_pulses", {endTransactionOut, busErrorOut}, 2'b00);
        reset = 1'b1;
        tick();
        chk("post_rst_idle", {grants, busIdle}, {4'b0000, 1'b1});

        // Alternating masters 0 and 2.
        requests = 4'b0101;
        one_beat_txn("rr1", 4'b0001);
        one_beat_txn("rr2", 4'b0100);
        one_beat_txn("rr3", 4'b0001);
        one_beat_txn("rr4", 4'b0100);
        requests = 4'b0000;
        chk("rr_last", activeMaster, 2'd2);

        // Begin timeout on master 3.
        requests = 4'b1000;
        tick();
        chk("bto_grant", grants, 4'b1000);
        chk("bto_master", activeMaster, 2'd3);
        early_pulses = 0;
        for (int i = 1; i < 16; i++) begin
            if (busErrorOut !== 1'b0) early_pulses++;
            tick();
        end
        chk("bto_no_early", early_pulses, 0);
        chk("bto_pulse", {busErrorOut, endTransactionOut, grants}, {1'b1, 1'b0, 4'b1000});
        tick();
        chk("bto_release", {grants, busIdle, busErrorOut}, {4'b0000, 1'b0, 1'b0});
        tick();
        chk("bto_idle", busIdle, 1'b1);
        tick();
        chk("bto_regrant", grants, 4'b1000);
        beginTransactionIn = 1'b1;
        tick();
        beginTransactionIn = 1'b0;
        endTransactionIn   = 1'b1;
        tick();
        endTransactionIn = 1'b0;
        requests         = 4'b0000;
        tick();
        chk("bto_done_idle", busIdle, 1'b1);

        // Idle watchdog on master 2.
        requests = 4'b0100;
        tick();
        chk("wd_grant", grants, 4'b0100);
        beginTransactionIn = 1'b1;
        tick();
        beginTransactionIn = 1'b0;
        early_pulses = 0;
        for (int i = 1; i < 1024; i++) begin
            if (endTransactionOut !== 1'b0 || busErrorOut !== 1'b0) early_pulses++;
            tick();
        end
        chk("wd_no_early", early_pulses, 0);
        chk("wd_pulses", {endTransactionOut, busErrorOut, grants}, {1'b1, 1'b1, 4'b0100});
        tick();
        chk("wd_release", {grants, busIdle, endTransactionOut, busErrorOut},
            {4'b0000, 1'b0, 1'b0, 1'b0});
        requests = 4'b0000;
        tick();
        chk("wd_idle", busIdle, 1'b1);

        // Simultaneous slave error and end: master 1 wins (order 3,0,1).
        requests = 4'b0010;
        tick();
        chk("se_grant", grants, 4'b0010);
        beginTransactionIn = 1'b1;
        tick();
        beginTransactionIn = 1'b0;
        busErrorIn         = 1'b1;
        endTransactionIn   = 1'b1;
        #1;
        chk("se_no_pulses", {endTransactionOut, busErrorOut}, 2'b00);
        tick();
        busErrorIn       = 1'b0;
        endTransactionIn = 1'b0;
        chk("se_release", {grants, busIdle, busErrorOut}, {4'b0000, 1'b0, 1'b0});
        tick();
        chk("se_idle", busIdle, 1'b1);
        tick();
        chk("se_regrant_single", grants, 4'b0010);

        // Reset in the middle of a transaction.
        beginTransactionIn = 1'b1;
        tick();
        beginTransactionIn = 1'b0;
        chk("mr_active", {grants, busIdle}, {4'b0010, 1'b0});
        reset    = 1'b0;
        requests = 4'b1011;
        tick();
        chk("mr_cleared", {grants, busIdle, activeMaster}, {4'b0000, 1'b1, 2'd3});
        reset = 1'b1;
        tick();
        chk("mr_first_grant", grants, 4'b0001);

        // Winner withdraws during GRANT; other requests do not preempt.
        requests = 4'b1010;
        #1;
        chk("wdr_no_pulses", {endTransactionOut, busErrorOut}, 2'b00);
        tick();
        chk("wdr_release", {grants, busIdle, endTransactionOut, busErrorOut},
            {4'b0000, 1'b0, 1'b0, 1'b0});
        tick();
        chk("wdr_idle", {grants, busIdle}, {4'b0000, 1'b1});
        tick();
        chk("wdr_next_grant", grants, 4'b0010);
        requests           = 4'b0000;
        beginTransactionIn = 1'b1;
        tick();
        beginTransactionIn = 1'b0;
        endTransactionIn   = 1'b1;
        tick();
        endTransactionIn = 1'b0;
        tick();
        chk("wdr_done_idle", busIdle, 1'b1);

        // Bus inputs while IDLE with no requests are ignored.
        beginTransactionIn = 1'b1;
        endTransactionIn   = 1'b1;
        busErrorIn         = 1'b1;
        #1;
        chk("idle_in_pulses", {endTransactionOut, busErrorOut}, 2'b00);
        tick();
        tick();
        chk("idle_ignored", {grants, busIdle}, {4'b0000, 1'b1});
        beginTransactionIn = 1'b0;
        endTransactionIn   = 1'b0;
        busErrorIn         = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
